mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64 (`RegWidth`), SHALL set request address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  SHALL be asynchronous, active-low reset.
REQ-004 ifu_req_valid  input  1  fetch request present.
REQ-005 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-006 ifu_req_addr  input  ADDR_W  fetch byte address (PC).
REQ-007 ifu_resp_valid  output  1  instruction available.
REQ-008 ifu_resp_ready  input  1  IFU consumes instruction.
REQ-009 ifu_resp_inst  output  32  selected instruction word.
REQ-010 lsu_req_valid / lsu_req_ready  input / output  1 each  LSU request handshake.
REQ-011 lsu_req_addr  input  ADDR_W  data byte address.
REQ-012 lsu_req_wen, lsu_req_wdata, lsu_req_wmask  input  1, 64, 8  write enable, data, byte mask.
REQ-013 lsu_resp_valid / lsu_resp_ready  output / input  1 each  LSU response handshake.
REQ-014 lsu_resp_data  output  64  read data; 0 for writes.
REQ-015 mem_req_valid / mem_req_ready  output / input  1 each  memory request handshake.
REQ-016 mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  output  ADDR_W, 1, 64, 8  registered copy of granted request.
REQ-017 mem_resp_valid, mem_resp_data  input  1, 64  memory response, 8-byte-aligned data, arrives >=1 cycle after mem request acceptance.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RESP; exactly one transaction outstanding.
REQ-019 IDLE: grant computed combinationally; only granted requester sees req_ready=1; on valid&ready latch addr/wen/wdata/wmask/owner, go REQ.
REQ-020 REQ: mem_req_valid=1 with latched fields stable until mem_req_ready=1, then WAIT.
REQ-021 WAIT: on mem_resp_valid latch mem_resp_data, go RESP; mem_resp_valid outside WAIT SHALL be ignored.
REQ-022 RESP: owner's resp_valid=1, data stable until resp_ready=1, then IDLE; non-owner resp_valid=0.
REQ-023 ifu_resp_inst SHALL be data[63:32] when latched addr[2]=1, else data[31:0].
REQ-024 Write transactions SHALL return lsu_resp_valid with lsu_resp_data=0.
REQ-025 Minimum latency: accept at cycle N, mem_req_valid N+1, response at N+3 when mem_req_ready=1 and mem_resp_valid one cycle later.
REQ-026 No req_ready in REQ/WAIT/RESP; a new request SHALL be accepted no earlier than the cycle after RESP handshake.

Reset
REQ-027 rst_n low SHALL force IDLE, clear latched fields to 0, all valid/ready outputs 0, rr pointer to IFU-last.
REQ-028 Reset mid-transaction SHALL abandon it; no response delivered afterwards.

Configuration
REQ-029 Without ARB_RR_EN: fixed priority, LSU wins simultaneous requests.
REQ-030 With ARB_RR_EN: round-robin; on simultaneous requests the requester not granted last wins; pointer updates on each accepted request.

Structure
REQ-031 Owner enum (OWN_IFU, OWN_LSU), FSM state typedef and width constants SHALL live in shared package cpu_pkg.
REQ-032 Grant logic SHALL be sub-module arb_pick (two requests, last-grant input, one-hot grant out).

Verification
REQ-033 IFU read addr 0x80000004, mem_resp_data 0x11112222_33334444 -> ifu_resp_inst 0x11112222 at N+3.
REQ-034 IFU and LSU valid same cycle, no macro -> LSU granted; IFU granted next transaction.
REQ-035 ARB_RR_EN, both requesting continuously for 4 transactions -> grants alternate LSU, IFU, LSU, IFU (from reset pointer).
REQ-036 LSU write wmask 0x0F, mem_req_ready held low 3 cycles -> mem fields stable 4 cycles, lsu_resp_data=0.
REQ-037 ifu_resp_ready low 5 cycles in RESP -> inst held stable, no new request accepted.
REQ-038 rst_n asserted in WAIT, stale mem_resp_valid after release -> no resp_valid, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared owner/state types and width constants for the memory arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int RegWidth  = 64;
    localparam int DataWidth = 64;
    localparam int InstWidth = 32;
    localparam int MaskWidth = 8;

    // One-hot grant bit positions produced by arb_pick
    localparam int GntIfu = 0;
    localparam int GntLsu = 1;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
//  Module   : arb_pick
//  Brief    : Two-way grant picker. Fixed LSU priority by default; round-robin
//             when ARB_RR_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module arb_pick
    import cpu_pkg::*;
(
    input  logic       req_ifu_i,
    input  logic       req_lsu_i,
    input  owner_e     last_i,
    output logic [1:0] grant_o
);

`ifdef ARB_RR_EN
    always_comb begin
        grant_o = 2'b00;
        if (req_ifu_i && req_lsu_i) begin
            // On contention, favour whoever was not served last
            grant_o[GntLsu] = (last_i == OWN_IFU);
            grant_o[GntIfu] = (last_i == OWN_LSU);
        end else begin
            grant_o[GntLsu] = req_lsu_i;
            grant_o[GntIfu] = req_ifu_i;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last   = last_i;
    assign grant_o[GntLsu] = req_lsu_i;
    assign grant_o[GntIfu] = req_ifu_i & ~req_lsu_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Single-outstanding IFU/LSU arbiter onto one memory port.
//             Macro ARB_RR_EN selects round-robin instead of LSU priority.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = RegWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 ifu_req_valid_i,
    output logic                 ifu_req_ready_o,
    input  logic [ADDR_W-1:0]    ifu_req_addr_i,
    output logic                 ifu_resp_valid_o,
    input  logic                 ifu_resp_ready_i,
    output logic [InstWidth-1:0] ifu_resp_inst_o,

    input  logic                 lsu_req_valid_i,
    output logic                 lsu_req_ready_o,
    input  logic [ADDR_W-1:0]    lsu_req_addr_i,
    input  logic                 lsu_req_wen_i,
    input  logic [DataWidth-1:0] lsu_req_wdata_i,
    input  logic [MaskWidth-1:0] lsu_req_wmask_i,
    output logic                 lsu_resp_valid_o,
    input  logic                 lsu_resp_ready_i,
    output logic [DataWidth-1:0] lsu_resp_data_o,

    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ADDR_W-1:0]    mem_req_addr_o,
    output logic                 mem_req_wen_o,
    output logic [DataWidth-1:0] mem_req_wdata_o,
    output logic [MaskWidth-1:0] mem_req_wmask_o,
    input  logic                 mem_resp_valid_i,
    input  logic [DataWidth-1:0] mem_resp_data_i
);

    arb_state_e           state_q, state_d;
    owner_e               owner_q, owner_d;
    owner_e               last_q,  last_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic                 wen_q,   wen_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [MaskWidth-1:0] wmask_q, wmask_d;
    logic [DataWidth-1:0] data_q,  data_d;

    logic [1:0] w_grant;
    logic       w_ifu_ready;
    logic       w_lsu_ready;

    arb_pick u_arb_pick (
        .req_ifu_i (ifu_req_valid_i),
        .req_lsu_i (lsu_req_valid_i),
        .last_i    (last_q),
        .grant_o   (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        data_d      = data_q;
        w_ifu_ready = 1'b0;
        w_lsu_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_ifu_ready = w_grant[GntIfu];
                w_lsu_ready = w_grant[GntLsu];
                if (lsu_req_valid_i && w_grant[GntLsu]) begin
                    addr_d  = lsu_req_addr_i;
                    wen_d   = lsu_req_wen_i;
                    wdata_d = lsu_req_wdata_i;
                    wmask_d = lsu_req_wmask_i;
                    owner_d = OWN_LSU;
                    last_d  = OWN_LSU;
                    state_d = ST_REQ;
                end else if (ifu_req_valid_i && w_grant[GntIfu]) begin
                    addr_d  = ifu_req_addr_i;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWN_IFU;
                    last_d  = OWN_IFU;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    data_d  = mem_resp_data_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if ((owner_q == OWN_IFU && ifu_resp_ready_i) ||
                    (owner_q == OWN_LSU && lsu_resp_ready_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is masked by reset so a held-valid requester never sees a grant during reset
    assign ifu_req_ready_o  = w_ifu_ready & rst_n;
    assign lsu_req_ready_o  = w_lsu_ready & rst_n;

    assign mem_req_valid_o  = (state_q == ST_REQ);
    assign mem_req_addr_o   = addr_q;
    assign mem_req_wen_o    = wen_q;
    assign mem_req_wdata_o  = wdata_q;
    assign mem_req_wmask_o  = wmask_q;

    assign ifu_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_resp_inst_o  = addr_q[2] ? data_q[63:32] : data_q[31:0];
    assign lsu_resp_data_o  = wen_q ? '0 : data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter (honours ARB_RR_EN).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int ADDR_W = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
    logic [63:0] ifu_req_addr = '0;
    logic [31:0] ifu_resp_inst;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid, lsu_resp_ready = 1'b0;
    logic [63:0] lsu_req_addr = '0, lsu_req_wdata = '0, lsu_resp_data;
    logic        lsu_req_wen = 1'b0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ifu_req_valid_i  (ifu_req_valid),
        .ifu_req_ready_o  (ifu_req_ready),
        .ifu_req_addr_i   (ifu_req_addr),
        .ifu_resp_valid_o (ifu_resp_valid),
        .ifu_resp_ready_i (ifu_resp_ready),
        .ifu_resp_inst_o  (ifu_resp_inst),
        .lsu_req_valid_i  (lsu_req_valid),
        .lsu_req_ready_o  (lsu_req_ready),
        .lsu_req_addr_i   (lsu_req_addr),
        .lsu_req_wen_i    (lsu_req_wen),
        .lsu_req_wdata_i  (lsu_req_wdata),
        .lsu_req_wmask_i  (lsu_req_wmask),
        .lsu_resp_valid_o (lsu_resp_valid),
        .lsu_resp_ready_i (lsu_resp_ready),
        .lsu_resp_data_o  (lsu_resp_data),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_req_wen_o    (mem_req_wen),
        .mem_req_wdata_o  (mem_req_wdata),
        .mem_req_wmask_o  (mem_req_wmask),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        is_lsu;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] mdata;
        int          mreq_wait;
        int          resp_wait;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic lsu_side, input logic val);
        if (lsu_side) lsu_req_valid = val;
        else          ifu_req_valid = val;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check("rst_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
        check("rst_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
        tick;
        tick;
        check("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_resp_valid", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        check("rst_mem_addr", mem_req_addr, 64'd0);
        check("rst_mem_fields", {mem_req_wen, mem_req_wmask, 55'd0}, 64'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    // Drives memory handshake and response for an already-accepted request
    task automatic serve(input logic exp_lsu);
        mem_req_ready = 1'b1;
        #1;
        check("serve_mem_valid", {63'd0, mem_req_valid}, 64'd1);
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h1111_2222_3333_4444;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        check("serve_resp_owner", {62'd0, lsu_resp_valid, ifu_resp_valid},
              exp_lsu ? 64'd2 : 64'd1);
        check("serve_no_ready_resp", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd0);
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        tick;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] ewd;
        logic [7:0]  ewm;
        logic        ewen;
        logic        opp_ready;
        ewd  = v.is_lsu ? v.wdata : 64'd0;
        ewm  = v.is_lsu ? v.wmask : 8'd0;
        ewen = v.is_lsu ? v.wen   : 1'b0;
        if (v.is_lsu) begin
            lsu_req_addr  = v.addr;
            lsu_req_wen   = v.wen;
            lsu_req_wdata = v.wdata;
            lsu_req_wmask = v.wmask;
        end else begin
            ifu_req_addr  = v.addr;
        end
        set_valid(v.is_lsu, 1'b1);
        #1;
        check($sformatf("v%0d_req_ready", idx),
              {63'd0, (v.is_lsu ? lsu_req_ready : ifu_req_ready)}, 64'd1);
        check($sformatf("v%0d_mem_idle", idx), {63'd0, mem_req_valid}, 64'd0);
        tick;
        set_valid(v.is_lsu, 1'b0);
        lsu_req_addr  = 64'hBAD0_BAD0_BAD0_BAD0;
        ifu_req_addr  = 64'hBAD1_BAD1_BAD1_BAD1;
        lsu_req_wdata = ~v.wdata;
        lsu_req_wmask = ~v.wmask;
        lsu_req_wen   = ~v.wen;
        for (int c = 0; c <= v.mreq_wait; c++) begin
            if (c < v.mreq_wait) begin
                set_valid(!v.is_lsu, 1'b1);
                mem_resp_valid = 1'b1;
                mem_resp_data  = 64'hEEEE_EEEE_EEEE_EEEE;
            end else begin
                set_valid(!v.is_lsu, 1'b0);
                mem_resp_valid = 1'b0;
                mem_req_ready  = 1'b1;
            end
            #1;
            opp_ready = v.is_lsu ? ifu_req_ready : lsu_req_ready;
            check($sformatf("v%0d_c%0d_mem_valid", idx, c), {63'd0, mem_req_valid}, 64'd1);
            check($sformatf("v%0d_c%0d_mem_addr", idx, c), mem_req_addr, v.addr);
            check($sformatf("v%0d_c%0d_mem_wdata", idx, c), mem_req_wdata, ewd);
            check($sformatf("v%0d_c%0d_mem_wen_mask", idx, c),
                  {55'd0, mem_req_wen, mem_req_wmask}, {55'd0, ewen, ewm});
            check($sformatf("v%0d_c%0d_no_ready", idx, c), {63'd0, opp_ready}, 64'd0);
            tick;
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.mdata;
        #1;
        check($sformatf("v%0d_wait_state", idx),
              {61'd0, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        tick;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int c = 0; c <= v.resp_wait; c++) begin
            set_valid(!v.is_lsu, (c < v.resp_wait));
            if (c == v.resp_wait) begin
                if (v.is_lsu) lsu_resp_ready = 1'b1;
                else          ifu_resp_ready = 1'b1;
            end
            #1;
            opp_ready = v.is_lsu ? ifu_req_ready : lsu_req_ready;
            check($sformatf("v%0d_r%0d_resp_valid", idx, c),
                  {62'd0, lsu_resp_valid, ifu_resp_valid}, v.is_lsu ? 64'd2 : 64'd1);
            check($sformatf("v%0d_r%0d_data", idx, c),
                  v.is_lsu ? lsu_resp_data : {32'd0, ifu_resp_inst}, v.exp);
            check($sformatf("v%0d_r%0d_no_ready", idx, c), {63'd0, opp_ready}, 64'd0);
            tick;
        end
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        #1;
        check($sformatf("v%0d_done", idx),
              {61'd0, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    endtask

    logic exp_own [4];

    initial begin
        vecs[0] = '{1'b0, 64'h8000_0004, 1'b0, 64'd0, 8'h00,
                    64'h1111_2222_3333_4444, 0, 0, 64'h1111_2222};
        vecs[1] = '{1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00,
                    64'h1111_2222_3333_4444, 0, 5, 64'h3333_4444};
        vecs[2] = '{1'b1, 64'h8000_1008, 1'b0, 64'd0, 8'h00,
                    64'hDEAD_BEEF_CAFE_F00D, 2, 1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[3] = '{1'b1, 64'h8000_2000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F,
                    64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 64'd0};
        vecs[4] = '{1'b0, 64'h0000_000C, 1'b0, 64'd0, 8'h00,
                    64'hAAAA_5555_1234_5678, 1, 2, 64'hAAAA_5555};
`ifdef ARB_RR_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Simultaneous request: LSU first, then the waiting IFU
        do_reset();
        ifu_req_addr  = 64'h200;
        lsu_req_addr  = 64'h100;
        lsu_req_wen   = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check("sim_grant", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd2);
        tick;
        lsu_req_valid = 1'b0;
        check("sim_lsu_addr", mem_req_addr, 64'h100);
        serve(1'b1);
        #1;
        check("sim_ifu_next", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd1);
        tick;
        ifu_req_valid = 1'b0;
        check("sim_ifu_addr", mem_req_addr, 64'h200);
        serve(1'b0);

        // Both requesting back to back from the reset pointer
        do_reset();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            ifu_req_addr = 64'h1000 + 64'(t);
            lsu_req_addr = 64'h2000 + 64'(t);
            #1;
            check($sformatf("cont%0d_grant", t), {62'd0, lsu_req_ready, ifu_req_ready},
                  exp_own[t] ? 64'd2 : 64'd1);
            tick;
            check($sformatf("cont%0d_addr", t), mem_req_addr,
                  exp_own[t] ? 64'h2000 + 64'(t) : 64'h1000 + 64'(t));
            serve(exp_own[t]);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // Reset while waiting for memory, then a stale response
        do_reset();
        ifu_req_addr  = 64'h8000_0004;
        ifu_req_valid = 1'b1;
        tick;
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rstw_addr_clr", mem_req_addr, 64'd0);
        tick;
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h5555_6666_7777_8888;
        for (int c = 0; c < 3; c++) begin
            tick;
            check($sformatf("rstw_c%0d_no_resp", c),
                  {61'd0, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        end
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        #1;
        check("rstw_idle", {63'd0, ifu_req_ready}, 64'd1);
        ifu_req_valid  = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

endmodule

`default_nettype wire
